mdio_frontend: RTL
==================

Name: mdio_frontend

Overview:
Pad-side front end placed directly upstream of MDIO_top. It brings the asynchronous MDC/MDIO pad signals into the PCLK domain and deglitches them. It supplies clean MDC and MDIO_in levels to MDIO_top. It also hunts for the Clause-22 preamble/ST pattern and retimes MDIO_top's MDIO_out/mdio_oe onto the pad at MDC falling edges.

Parameters:
SYNC_STAGES, 2, synchroniser depth for MDC and MDIO pad inputs (min 2)
FILT_LEN, 3, consecutive identical synced samples required before a filtered level changes (1..7)
PRE_LEN, 32, consecutive 1 bits constituting a valid preamble
FRAME_BITS, 30, bits following ST before the frame ends (OP2+PHYAD5+REGAD5+TA2+DATA16)

Ports:
PCLK  in  1  system clock, sole clock
PRESETn  in  1  asynchronous active-low reset
MDC_pad  in  1  raw MDC from pad
MDIO_pad_in  in  1  raw MDIO input from pad
mdio_out_core  in  1  MDIO_out from MDIO_top
mdio_oe_core  in  1  mdio_oe from MDIO_top
MDC_core  out  1  filtered MDC, to MDIO_top.MDC
MDIO_in_core  out  1  filtered MDIO, to MDIO_top.MDIO_in
mdc_rise  out  1  one-cycle pulse on filtered MDC 0->1
mdc_fall  out  1  one-cycle pulse on filtered MDC 1->0
preamble_ok  out  1  level: PRE_LEN ones seen, ST not yet received
frame_start  out  1  one-cycle pulse when ST=01 completes
frame_active  out  1  level: inside a frame after ST
st_err  out  1  one-cycle pulse: ST second bit was 0
MDIO_pad_out  out  1  retimed MDIO output to pad
MDIO_pad_oe  out  1  retimed pad output enable

Behaviour:
- Reset (async, PRESETn=0): all synchroniser and filter flops 0; MDC_core=0, MDIO_in_core=1 (bus idle high); all pulses 0; preamble_ok=0; frame_active=0; MDIO_pad_out=0; MDIO_pad_oe=0; preamble counter 0; FSM=HUNT. Reset asserted mid-frame aborts the frame with no st_err/frame_start.
- Synchroniser: SYNC_STAGES flops per input.
- Filter: per signal, a counter of consecutive synced samples differing from the current filtered level. The filtered level toggles on the cycle the count reaches FILT_LEN, and the counter clears. Any sample equal to the filtered level clears the counter. Latency pad->core = SYNC_STAGES+FILT_LEN cycles.
- Edge pulses: mdc_rise/mdc_fall are asserted the cycle after MDC_core changes and last exactly 1 cycle.
- Bit sampling: on mdc_rise with MDIO_pad_oe=0, rx bit = MDIO_in_core. Bits sampled while MDIO_pad_oe=1 are ignored by the FSM, but the FRAME bit counter still advances.
- FSM states HUNT, PRE, ST1, FRAME:
  - HUNT: bit 1 -> cnt=1, go to PRE; bit 0 -> stay.
  - PRE: bit 1 -> cnt saturates at PRE_LEN. Bit 0 with cnt<PRE_LEN -> cnt=0, go to HUNT. Bit 0 with cnt=PRE_LEN -> ST1.
  - preamble_ok=1 in PRE with cnt=PRE_LEN.
  - ST1: bit 1 -> frame_start pulse, bitcnt=0, FRAME. Bit 0 -> st_err pulse, cnt=0, HUNT.
  - FRAME: frame_active=1. bitcnt increments on each mdc_rise. When bitcnt reaches FRAME_BITS-1 and that rise occurs -> HUNT, cnt=0.
- Output retime: on mdc_fall, MDIO_pad_out<=mdio_out_core and MDIO_pad_oe<=mdio_oe_core. Both hold otherwise. mdc_fall and a core change in the same cycle capture the new core value.

Optional Feature:
MDIO_PRE_SUPPRESS_EN. When defined: leaving FRAME enters PRE with cnt=PRE_LEN, so the next frame needs only one idle 1 bit then ST (preamble suppression). A 0 as the first bit after the frame -> HUNT, cnt=0. When undefined: leaving FRAME enters HUNT with cnt=0, and a full PRE_LEN preamble is always required.

Test Plan:
- Glitch: 2-cycle MDC_pad high pulse (FILT_LEN=3) -> MDC_core stays 0, no mdc_rise. 3-cycle pulse -> MDC_core rises exactly SYNC_STAGES+3 cycles after the pad edge.
- Valid frame: 32 ones, 0, 1, then 30 bits -> preamble_ok high after bit 32, frame_start pulse on ST's second rise, frame_active for 30 rises, then HUNT.
- Short preamble: 31 ones then 01 -> no frame_start, no st_err, FSM HUNT after the 0.
- Bad ST: 32 ones then 00 -> st_err single pulse, preamble_ok drops, no frame_start.
- Retime: toggle mdio_oe_core/mdio_out_core mid-MDC-high -> pad signals change only on the cycle after mdc_fall. Assert PRESETn=0 mid-FRAME -> all outputs at reset values immediately.
- MDIO_PRE_SUPPRESS_EN: after a valid frame, send 1,0,1 -> frame_start asserted; without the macro, same stimulus gives no frame_start.

Source files
------------

// File: rtl/mdio_frontend.sv
// Pad-side MDIO front end: synchronises and deglitches MDC/MDIO, hunts for the
// Clause-22 preamble/ST pattern and retimes the core's MDIO drive onto the pad at
// MDC falling edges. Define MDIO_PRE_SUPPRESS_EN to allow preamble suppression.
module mdio_frontend #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int PRE_LEN     = 32,
  parameter int FRAME_BITS  = 30
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic MDC_pad,
  input  logic MDIO_pad_in,
  input  logic mdio_out_core,
  input  logic mdio_oe_core,
  output logic MDC_core,
  output logic MDIO_in_core,
  output logic mdc_rise,
  output logic mdc_fall,
  output logic preamble_ok,
  output logic frame_start,
  output logic frame_active,
  output logic st_err,
  output logic MDIO_pad_out,
  output logic MDIO_pad_oe
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int PW = $clog2(PRE_LEN + 1);
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam logic [PW-1:0] PRE_MAX  = PW'(PRE_LEN);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);
  // Bit 0 is MDC (idles low), bit 1 is MDIO (bus idles high).
  localparam logic [1:0] LVL_RST = 2'b10;

  typedef enum logic [1:0] {HUNT, PRE, ST1, FRAME} state_t;

  logic [SYNC_STAGES-1:0] mdc_sync, mdio_sync;
  logic [1:0]             synced, level;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser chain.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      mdc_sync  <= '0;
      mdio_sync <= '0;
    end else begin
      mdc_sync  <= {mdc_sync[SYNC_STAGES-2:0], MDC_pad};
      mdio_sync <= {mdio_sync[SYNC_STAGES-2:0], MDIO_pad_in};
    end
  end

  assign synced = {mdio_sync[SYNC_STAGES-1], mdc_sync[SYNC_STAGES-1]};

  for (genvar g = 0; g < 2; g++) begin : g_filt
    logic [FW-1:0] run_cnt;
    logic          lvl_q;

    // run_cnt counts consecutive samples disagreeing with the filtered level.
    always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
        run_cnt <= '0;
        lvl_q   <= LVL_RST[g];
      end else if (synced[g] == lvl_q) begin
        run_cnt <= '0;
      end else if (run_cnt == FW'(FILT_LEN - 1)) begin
        run_cnt <= '0;
        lvl_q   <= ~lvl_q;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end

    assign level[g] = lvl_q;
  end

  assign MDC_core     = level[0];
  assign MDIO_in_core = level[1];

  logic mdc_prev;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      mdc_prev <= 1'b0;
      mdc_rise <= 1'b0;
      mdc_fall <= 1'b0;
    end else begin
      mdc_prev <= MDC_core;
      mdc_rise <= MDC_core & ~mdc_prev;
      mdc_fall <= ~MDC_core & mdc_prev;
    end
  end

  state_t        state_q, state_d;
  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic          post_frame_q, post_frame_d;
  logic          frame_start_d, st_err_d;
  logic          rx_valid;

  // Bits we drive ourselves are not part of the received pattern.
  assign rx_valid = mdc_rise & ~MDIO_pad_oe;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d       = state_q;
    pre_cnt_d     = pre_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    post_frame_d  = post_frame_q;
    frame_start_d = 1'b0;
    st_err_d      = 1'b0;
    case (state_q)
      HUNT: begin
        if (rx_valid && MDIO_in_core) begin
          pre_cnt_d = PW'(1);
          state_d   = PRE;
        end
      end
      PRE: begin
        if (rx_valid) begin
          post_frame_d = 1'b0;
          if (MDIO_in_core) begin
            if (pre_cnt_q != PRE_MAX) pre_cnt_d = pre_cnt_q + 1'b1;
          end else if (pre_cnt_q == PRE_MAX && !post_frame_q) begin
            state_d = ST1;
          end else begin
            pre_cnt_d = '0;
            state_d   = HUNT;
          end
        end
      end
      ST1: begin
        if (rx_valid) begin
          if (MDIO_in_core) begin
            frame_start_d = 1'b1;
            bit_cnt_d     = '0;
            state_d       = FRAME;
          end else begin
            st_err_d  = 1'b1;
            pre_cnt_d = '0;
            state_d   = HUNT;
          end
        end
      end
      FRAME: begin
        // Turnaround/data bits may be ours, so every rise counts here.
        if (mdc_rise) begin
          if (bit_cnt_q == BIT_LAST) begin
`ifdef MDIO_PRE_SUPPRESS_EN
            state_d      = PRE;
            pre_cnt_d    = PRE_MAX;
            post_frame_d = 1'b1;
`else
            state_d      = HUNT;
            pre_cnt_d    = '0;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q      <= HUNT;
      pre_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      post_frame_q <= 1'b0;
      frame_start  <= 1'b0;
      st_err       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      post_frame_q <= post_frame_d;
      frame_start  <= frame_start_d;
      st_err       <= st_err_d;
    end
  end

  assign preamble_ok  = (state_q == PRE) && (pre_cnt_q == PRE_MAX);
  assign frame_active = (state_q == FRAME);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      MDIO_pad_out <= 1'b0;
      MDIO_pad_oe  <= 1'b0;
    end else if (mdc_fall) begin
      MDIO_pad_out <= mdio_out_core;
      MDIO_pad_oe  <= mdio_oe_core;
    end
  end

endmodule
